// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// led_scan_ctrl : frame-synchronised multiplexed hex-digit scanner for led_7seg
// Rev 1.0
// ============================================================================
module led_scan_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_wr_en,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic                      i_display_on,
  output logic [3:0]                o_val,
  output logic                      o_en,
  output logic [DATA_WIDTH/4-1:0]   o_digit_sel,
  output logic                      o_frame_done,
  output logic                      o_pending
);

  localparam int NUM_DIGITS = DATA_WIDTH / 4;
  localparam int CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_BLANK    = CNT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0] c_DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4) begin : g_bad_width
    $error("led_scan_ctrl: DATA_WIDTH must be a positive multiple of 4");
  end
  if (BLANK_CYCLES < 1 || SCAN_DIV < BLANK_CYCLES + 1) begin : g_bad_timing
    $error("led_scan_ctrl: need BLANK_CYCLES >= 1 and SCAN_DIV >= BLANK_CYCLES+1");
  end

  logic [CNT_W-1:0]      r_cnt;
  logic [DIG_W-1:0]      r_dig;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] r_display;
  logic                  r_pending;
  logic                  r_on_q;
  logic                  r_frame_done;

  logic                  w_boundary;
  logic [3:0]            w_val;
  logic [NUM_DIGITS-1:0] w_sel;

  assign w_boundary = (r_cnt == c_CNT_LAST) && (r_dig == c_DIG_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_dig        <= '0;
      r_shadow     <= '0;
      r_display    <= '0;
      r_pending    <= 1'b0;
      r_on_q       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_on_q       <= i_display_on;
      r_frame_done <= w_boundary;

      if (r_cnt == c_CNT_LAST) begin
        r_cnt <= '0;
        r_dig <= (r_dig == c_DIG_LAST) ? '0 : r_dig + DIG_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (i_wr_en) begin
        r_shadow <= i_wr_data;
      end

      // A write landing on the boundary bypasses the shadow so it is shown
      // from the first cycle of the new frame and never reports pending.
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (i_wr_en) begin
          r_display <= i_wr_data;
        end else if (r_pending) begin
          r_display <= r_shadow;
        end
      end else if (i_wr_en) begin
        r_pending <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_sel[gi] = (r_dig == DIG_W'(gi));
  end

  always_comb begin
    w_val = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel[i]) begin
        w_val = r_display[4*i +: 4];
      end
    end
  end

  assign o_val        = w_val;
  assign o_digit_sel  = w_sel;
  assign o_en         = r_on_q && (r_cnt >= c_BLANK);
  assign o_frame_done = r_frame_done;
  assign o_pending    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_led_scan_ctrl : randomized bench against a cycle-indexed reference model
// Rev 1.0
// ============================================================================
module tb_led_scan_ctrl;

  localparam int DW    = 8;
  localparam int SD    = 8;
  localparam int BLANK = 2;
  localparam int ND    = DW / 4;
  localparam int FRAME = ND * SD;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          display_on;
  logic [3:0]    val;
  logic          en;
  logic [ND-1:0] digit_sel;
  logic          frame_done;
  logic          pending;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: cycles since reset release plus the architectural values.
  int            t;
  logic [DW-1:0] m_shadow;
  logic [DW-1:0] m_disp;
  bit            m_pend;
  bit            m_onq;

  led_scan_ctrl #(
    .DATA_WIDTH   (DW),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BLANK)
  ) u_dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_wr_en      (wr_en),
    .i_wr_data    (wr_data),
    .i_display_on (display_on),
    .o_val        (val),
    .o_en         (en),
    .o_digit_sel  (digit_sel),
    .o_frame_done (frame_done),
    .o_pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    m_shadow = '0;
    m_disp   = '0;
    m_pend   = 0;
    m_onq    = 0;
  endtask

  task automatic check_outputs();
    int cnt, dig;
    cnt = t % SD;
    dig = (t / SD) % ND;
    chk("val",        32'(val),        32'((m_disp >> (4 * dig)) & 8'h0F));
    chk("en",         32'(en),         32'(m_onq && (cnt >= BLANK)));
    chk("digit_sel",  32'(digit_sel),  32'(1 << dig));
    chk("frame_done", 32'(frame_done), 32'((t != 0) && (t % FRAME == 0)));
    chk("pending",    32'(pending),    32'(m_pend));
  endtask

  // Applies the effect of the coming clock edge given the inputs now driven.
  task automatic model_step();
    if (t % FRAME == FRAME - 1) begin
      if (wr_en) begin
        m_shadow = wr_data;
        m_disp   = wr_data;
      end else if (m_pend) begin
        m_disp = m_shadow;
      end
      m_pend = 0;
    end else if (wr_en) begin
      m_shadow = wr_data;
      m_pend   = 1;
    end
    m_onq = display_on;
    t++;
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_outputs();
      // Boundary cycles get extra write pressure so bypass commits are common.
      if (t % FRAME == FRAME - 1)
        wr_en = ($urandom_range(0, 1) == 1);
      else
        wr_en = ($urandom_range(0, 5) == 0);
      wr_data = DW'($urandom);
      if ($urandom_range(0, 19) == 0) display_on = ~display_on;
      model_step();
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    display_on = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    run_random(400);

    // Asynchronous reset mid-slot: outputs must clear before any clock edge.
    wr_en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_val",       32'(val),        32'h0);
    chk("rst_en",        32'(en),         32'h0);
    chk("rst_digit_sel", 32'(digit_sel),  32'h1);
    chk("rst_frame",     32'(frame_done), 32'h0);
    chk("rst_pending",   32'(pending),    32'h0);
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    display_on = 1'b1;
    model_reset();
    #1;

    run_random(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
